// File: rtl/corr_acq_ctrl_if.sv
// Control/status bundle between the channel registers, the correlator datapath
// and the acquisition sequencer.
interface corr_acq_ctrl_if #(
    parameter int unsigned PHASE_WIDTH = 12,
    parameter int unsigned POW_WIDTH   = 48
);
    logic                   start;
    logic                   abort;
    logic [POW_WIDTH-1:0]   threshold;
    logic [POW_WIDTH-1:0]   corr_pow;
    logic                   tx_phase_load;
    logic [PHASE_WIDTH-1:0] tx_code_phase;
    logic                   tx_prn_sop;
    logic                   tx_prn_eop;
    logic                   busy;
    logic                   done;
    logic                   found;
    logic [POW_WIDTH-1:0]   peak_pow;
    logic [PHASE_WIDTH-1:0] peak_phase;

    modport master (
        output start, abort, threshold, corr_pow,
        input  tx_phase_load, tx_code_phase, tx_prn_sop, tx_prn_eop,
               busy, done, found, peak_pow, peak_phase
    );

    modport slave (
        input  start, abort, threshold, corr_pow,
        output tx_phase_load, tx_code_phase, tx_prn_sop, tx_prn_eop,
               busy, done, found, peak_pow, peak_phase
    );
endinterface

// File: rtl/corr_acq_ctrl.sv
// Code-phase acquisition sequencer: sweeps hypotheses, frames PRN periods for the
// correlator and tracks peak power / detection against a threshold.
module corr_acq_ctrl #(
    parameter int unsigned PRN_LEN     = 2046,
    parameter int unsigned PHASE_NUM   = 2046,
    parameter int unsigned PHASE_WIDTH = 12,
    parameter int unsigned POW_LAT     = 3,
    parameter int unsigned POW_WIDTH   = 48
) (
    input  logic            rx_clk,
    input  logic            rx_rst,
    corr_acq_ctrl_if.slave  bus
);
    localparam int unsigned CHIP_W = (PRN_LEN > 1) ? $clog2(PRN_LEN) : 1;
    localparam int unsigned LAT_W  = (POW_LAT > 1) ? $clog2(POW_LAT) : 1;
    localparam logic [CHIP_W-1:0]      CHIP_LAST  = CHIP_W'(PRN_LEN - 1);
    localparam logic [LAT_W-1:0]       LAT_LAST   = LAT_W'(POW_LAT - 1);
    localparam logic [PHASE_WIDTH-1:0] PHASE_LAST = PHASE_WIDTH'(PHASE_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ACCUM, S_WAIT_POW, S_EVAL, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CHIP_W-1:0]      chip_q, chip_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [PHASE_WIDTH-1:0] phase_d;
    logic [POW_WIDTH-1:0]   peak_pow_d;
    logic [PHASE_WIDTH-1:0] peak_phase_d;
    logic                   found_d;

    // Next-state and next-value logic; abort out of any active state wins.
    always_comb begin
        state_d      = state_q;
        chip_d       = chip_q;
        lat_d        = lat_q;
        phase_d      = bus.tx_code_phase;
        peak_pow_d   = bus.peak_pow;
        peak_phase_d = bus.peak_phase;
        found_d      = bus.found;

        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d      = S_LOAD;
                        phase_d      = '0;
                        peak_pow_d   = '0;
                        peak_phase_d = '0;
                        found_d      = 1'b0;
                    end
                end
                S_LOAD: begin
                    state_d = S_ACCUM;
                    chip_d  = '0;
                end
                S_ACCUM: begin
                    if (chip_q == CHIP_LAST) begin
                        chip_d  = '0;
                        lat_d   = LAT_W'(1);
                        state_d = (POW_LAT == 1) ? S_EVAL : S_WAIT_POW;
                    end else begin
                        chip_d = chip_q + CHIP_W'(1);
                    end
                end
                S_WAIT_POW: begin
                    if (lat_q == LAT_LAST) state_d = S_EVAL;
                    else                   lat_d   = lat_q + LAT_W'(1);
                end
                S_EVAL: begin
                    // Strict compare keeps the earliest phase on ties.
                    if (bus.corr_pow > bus.peak_pow) begin
                        peak_pow_d   = bus.corr_pow;
                        peak_phase_d = bus.tx_code_phase;
                    end
                    if (bus.corr_pow >= bus.threshold) found_d = 1'b1;
                    if (bus.tx_code_phase == PHASE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        phase_d = bus.tx_code_phase + PHASE_WIDTH'(1);
                        state_d = S_LOAD;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs; strobes decode the upcoming state.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q           <= S_IDLE;
            chip_q            <= '0;
            lat_q             <= '0;
            bus.tx_code_phase <= '0;
            bus.peak_pow      <= '0;
            bus.peak_phase    <= '0;
            bus.found         <= 1'b0;
            bus.tx_phase_load <= 1'b0;
            bus.tx_prn_sop    <= 1'b0;
            bus.tx_prn_eop    <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            state_q           <= state_d;
            chip_q            <= chip_d;
            lat_q             <= lat_d;
            bus.tx_code_phase <= phase_d;
            bus.peak_pow      <= peak_pow_d;
            bus.peak_phase    <= peak_phase_d;
            bus.found         <= found_d;
            bus.tx_phase_load <= (state_d == S_LOAD);
            bus.tx_prn_sop    <= (state_d == S_ACCUM) && (chip_d == '0);
            bus.tx_prn_eop    <= (state_d == S_ACCUM) && (chip_d == CHIP_LAST);
            bus.busy          <= (state_d inside {S_LOAD, S_ACCUM, S_WAIT_POW, S_EVAL});
            bus.done          <= (state_d == S_DONE);
        end
    end
endmodule

// File: tb/tb_corr_acq_ctrl.sv
// Scoreboard bench: strobe events are queued at start and matched cycle-exactly.
module tb_corr_acq_ctrl;
    localparam int PW  = 12;
    localparam int WW  = 48;
    localparam int A_P = 12;   // 8 + 3 + 1
    localparam int B_P = 3;    // 1 + 1 + 1
    localparam logic [3:0] K_LOAD = 4'b0001;
    localparam logic [3:0] K_SOP  = 4'b0010;
    localparam logic [3:0] K_EOP  = 4'b0100;
    localparam logic [3:0] K_DONE = 4'b1000;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } ev_t;

    logic rx_clk = 1'b0;
    logic rx_rst = 1'b1;
    always #5 rx_clk = ~rx_clk;

    corr_acq_ctrl_if #(.PHASE_WIDTH(PW), .POW_WIDTH(WW)) bus_a ();
    corr_acq_ctrl_if #(.PHASE_WIDTH(PW), .POW_WIDTH(WW)) bus_b ();

    corr_acq_ctrl #(.PRN_LEN(8), .PHASE_NUM(4), .PHASE_WIDTH(PW), .POW_LAT(3), .POW_WIDTH(WW))
        dut_a (.rx_clk(rx_clk), .rx_rst(rx_rst), .bus(bus_a));
    corr_acq_ctrl #(.PRN_LEN(1), .PHASE_NUM(2), .PHASE_WIDTH(PW), .POW_LAT(1), .POW_WIDTH(WW))
        dut_b (.rx_clk(rx_clk), .rx_rst(rx_rst), .bus(bus_b));

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    ev_t q_a[$];
    ev_t q_b[$];
    int  a_t0 = 0, a_blo = 0, a_bhi = 0;
    int  b_t0 = 0, b_blo = 0, b_bhi = 0;
    bit  a_run = 1'b0, b_run = 1'b0;
    logic [WW-1:0] tab_a [4];
    logic [WW-1:0] tab_b [2];

    always @(posedge rx_clk) cyc <= cyc + 1;

    // corr_pow carries the table value only in expected EVAL cycles, a decoy otherwise.
    always @(negedge rx_clk) begin
        int rel;
        rel = cyc - a_t0;
        if (a_run && rel >= 1 && (rel - 1) % A_P == A_P - 1 && (rel - 1) / A_P < 4)
            bus_a.corr_pow = tab_a[(rel - 1) / A_P];
        else
            bus_a.corr_pow = 48'd999;
        rel = cyc - b_t0;
        if (b_run && rel >= 1 && (rel - 1) % B_P == B_P - 1 && (rel - 1) / B_P < 2)
            bus_b.corr_pow = tab_b[(rel - 1) / B_P];
        else
            bus_b.corr_pow = 48'd999;
    end

    // Strobe and busy monitor for dut_a.
    always @(negedge rx_clk) begin
        logic [3:0] obs;
        ev_t e;
        if (mon_en) begin
            obs = {bus_a.done, bus_a.tx_prn_eop, bus_a.tx_prn_sop, bus_a.tx_phase_load};
            n_tests++;
            if (bus_a.busy !== (cyc >= a_blo && cyc < a_bhi)) begin
                n_fail++;
                $display("FAIL busy_a cyc=%0d got=%b want=%b", cyc, bus_a.busy, (cyc >= a_blo && cyc < a_bhi));
            end
            if (q_a.size() != 0 && q_a[0].cyc < cyc) begin
                n_tests++; n_fail++;
                e = q_a.pop_front();
                $display("FAIL missed_a got=none want kind=%b at cyc=%0d", e.kind, e.cyc);
            end
            if (obs !== 4'b0) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe_a cyc=%0d got=%b want=none", cyc, obs);
                end else begin
                    e = q_a.pop_front();
                    if (e.cyc != cyc || e.kind !== obs) begin
                        n_fail++;
                        $display("FAIL strobe_a got kind=%b cyc=%0d want kind=%b cyc=%0d", obs, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    // Strobe and busy monitor for dut_b.
    always @(negedge rx_clk) begin
        logic [3:0] obs;
        ev_t e;
        if (mon_en) begin
            obs = {bus_b.done, bus_b.tx_prn_eop, bus_b.tx_prn_sop, bus_b.tx_phase_load};
            n_tests++;
            if (bus_b.busy !== (cyc >= b_blo && cyc < b_bhi)) begin
                n_fail++;
                $display("FAIL busy_b cyc=%0d got=%b want=%b", cyc, bus_b.busy, (cyc >= b_blo && cyc < b_bhi));
            end
            if (q_b.size() != 0 && q_b[0].cyc < cyc) begin
                n_tests++; n_fail++;
                e = q_b.pop_front();
                $display("FAIL missed_b got=none want kind=%b at cyc=%0d", e.kind, e.cyc);
            end
            if (obs !== 4'b0) begin
                n_tests++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe_b cyc=%0d got=%b want=none", cyc, obs);
                end else begin
                    e = q_b.pop_front();
                    if (e.cyc != cyc || e.kind !== obs) begin
                        n_fail++;
                        $display("FAIL strobe_b got kind=%b cyc=%0d want kind=%b cyc=%0d", obs, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push_ev(input bit b, input int c, input logic [3:0] k, input int last);
        ev_t e;
        if (c > last) return;
        e.cyc  = c;
        e.kind = k;
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
    endtask

    // Pulse start and queue every strobe up to cycle t0+stop_rel (stop_rel<0: full sweep).
    task automatic launch(input bit b, input int stop_rel);
        int prn, n, per, t0, last, c, bhi;
        prn = b ? 1 : 8;
        n   = b ? 2 : 4;
        per = b ? B_P : A_P;
        @(negedge rx_clk);
        t0   = cyc;
        last = (stop_rel < 0) ? t0 + 1 + n * per : t0 + stop_rel;
        bhi  = (stop_rel < 0) ? t0 + 1 + n * per : t0 + stop_rel + 1;
        for (int p = 0; p < n; p++) begin
            c = t0 + 1 + p * per;
            push_ev(b, c, K_LOAD, last);
            if (prn == 1) push_ev(b, c + 1, K_SOP | K_EOP, last);
            else begin
                push_ev(b, c + 1, K_SOP, last);
                push_ev(b, c + prn, K_EOP, last);
            end
        end
        push_ev(b, t0 + 1 + n * per, K_DONE, last);
        if (b) begin
            b_t0 = t0; b_run = 1'b1; b_blo = t0 + 1; b_bhi = bhi; bus_b.start = 1'b1;
        end else begin
            a_t0 = t0; a_run = 1'b1; a_blo = t0 + 1; a_bhi = bhi; bus_a.start = 1'b1;
        end
        @(negedge rx_clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int k = 0;
        while (bus_a.done !== 1'b1 && k < 200) begin @(negedge rx_clk); k++; end
        n_tests++;
        if (bus_a.done !== 1'b1 || cyc != a_t0 + 49) begin
            n_fail++;
            $display("FAIL %s_done got done=%b rel=%0d want done=1 rel=49", name, bus_a.done, cyc - a_t0);
        end
    endtask

    task automatic drain_a(input string name);
        repeat (4) @(negedge rx_clk);
        a_run = 1'b0;
        n_tests++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got %0d pending events want 0", name, q_a.size());
            q_a.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge rx_clk);
        n_tests += 6;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin n_fail++; $display("FAIL rst_status got busy=%b done=%b want 0 0", bus_a.busy, bus_a.done); end
        if (bus_a.found !== 1'b0) begin n_fail++; $display("FAIL rst_found got=%b want=0", bus_a.found); end
        if (bus_a.peak_pow !== '0) begin n_fail++; $display("FAIL rst_peak_pow got=%0d want=0", bus_a.peak_pow); end
        if (bus_a.peak_phase !== '0 || bus_a.tx_code_phase !== '0) begin n_fail++; $display("FAIL rst_phase got=%0d/%0d want=0/0", bus_a.peak_phase, bus_a.tx_code_phase); end
        if ({bus_a.tx_phase_load, bus_a.tx_prn_sop, bus_a.tx_prn_eop} !== 3'b0) begin n_fail++; $display("FAIL rst_strobes_a got=%b want=000", {bus_a.tx_phase_load, bus_a.tx_prn_sop, bus_a.tx_prn_eop}); end
        if ({bus_b.busy, bus_b.tx_prn_sop, bus_b.found} !== 3'b0) begin n_fail++; $display("FAIL rst_b got=%b want=000", {bus_b.busy, bus_b.tx_prn_sop, bus_b.found}); end
        rx_rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge rx_clk);
    endtask

    task automatic test_sweep(input logic [WW-1:0] thr, input logic want_found, input string name);
        tab_a[0] = 48'd10; tab_a[1] = 48'd50; tab_a[2] = 48'd30; tab_a[3] = 48'd50;
        bus_a.threshold = thr;
        launch(1'b0, -1);
        wait_done_a(name);
        n_tests += 3;
        if (bus_a.peak_pow !== 48'd50) begin n_fail++; $display("FAIL %s_peak_pow got=%0d want=50", name, bus_a.peak_pow); end
        if (bus_a.peak_phase !== 12'd1) begin n_fail++; $display("FAIL %s_peak_phase got=%0d want=1", name, bus_a.peak_phase); end
        if (bus_a.found !== want_found) begin n_fail++; $display("FAIL %s_found got=%b want=%b", name, bus_a.found, want_found); end
        drain_a(name);
    endtask

    task automatic test_abort();
        bus_a.threshold = 48'd40;
        launch(1'b0, 20);
        while (cyc < a_t0 + 20) @(negedge rx_clk);
        bus_a.abort = 1'b1;
        @(negedge rx_clk);
        bus_a.abort = 1'b0;
        repeat (50) @(negedge rx_clk);
        n_tests += 3;
        if (bus_a.peak_pow !== 48'd10) begin n_fail++; $display("FAIL abort_peak_pow got=%0d want=10", bus_a.peak_pow); end
        if (bus_a.peak_phase !== 12'd0) begin n_fail++; $display("FAIL abort_peak_phase got=%0d want=0", bus_a.peak_phase); end
        if (bus_a.found !== 1'b0) begin n_fail++; $display("FAIL abort_found got=%b want=0", bus_a.found); end
        drain_a("abort");
    endtask

    task automatic test_start_abort_idle();
        @(negedge rx_clk);
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        @(negedge rx_clk);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        repeat (5) @(negedge rx_clk);
        n_tests += 2;
        if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy got=%b want=0", bus_a.busy); end
        if (bus_a.peak_pow !== 48'd10) begin n_fail++; $display("FAIL start_abort_peak got=%0d want=10", bus_a.peak_pow); end
    endtask

    task automatic test_start_while_busy();
        bus_a.threshold = 48'd40;
        launch(1'b0, -1);
        while (cyc < a_t0 + 20) @(negedge rx_clk);
        bus_a.start = 1'b1;
        @(negedge rx_clk);
        bus_a.start = 1'b0;
        wait_done_a("restart");
        n_tests++;
        if (bus_a.peak_pow !== 48'd50) begin n_fail++; $display("FAIL restart_peak got=%0d want=50", bus_a.peak_pow); end
        drain_a("restart");
    endtask

    task automatic test_async_reset();
        bus_a.threshold = 48'd5;
        launch(1'b0, -1);
        while (cyc < a_t0 + 13) @(negedge rx_clk);
        @(posedge rx_clk);
        #2;
        n_tests += 2;
        if (bus_a.tx_prn_sop !== 1'b1) begin n_fail++; $display("FAIL pre_rst_sop got=%b want=1", bus_a.tx_prn_sop); end
        if (bus_a.found !== 1'b1) begin n_fail++; $display("FAIL pre_rst_found got=%b want=1", bus_a.found); end
        rx_rst = 1'b1;
        a_blo = 0; a_bhi = 0; a_run = 1'b0;
        q_a.delete();
        #1;
        n_tests += 4;
        if ({bus_a.busy, bus_a.tx_prn_sop, bus_a.tx_prn_eop, bus_a.tx_phase_load} !== 4'b0) begin n_fail++; $display("FAIL arst_strobes got=%b want=0000", {bus_a.busy, bus_a.tx_prn_sop, bus_a.tx_prn_eop, bus_a.tx_phase_load}); end
        if (bus_a.found !== 1'b0) begin n_fail++; $display("FAIL arst_found got=%b want=0", bus_a.found); end
        if (bus_a.peak_pow !== '0) begin n_fail++; $display("FAIL arst_peak_pow got=%0d want=0", bus_a.peak_pow); end
        if (bus_a.tx_code_phase !== '0) begin n_fail++; $display("FAIL arst_phase got=%0d want=0", bus_a.tx_code_phase); end
        @(negedge rx_clk);
        rx_rst = 1'b0;
        @(negedge rx_clk);
        test_sweep(48'd40, 1'b1, "post_rst");
    endtask

    task automatic test_min_config();
        int k = 0;
        tab_b[0] = 48'd7; tab_b[1] = 48'd9;
        bus_b.threshold = 48'd8;
        launch(1'b1, -1);
        while (bus_b.done !== 1'b1 && k < 50) begin @(negedge rx_clk); k++; end
        n_tests += 4;
        if (bus_b.done !== 1'b1 || cyc != b_t0 + 7) begin n_fail++; $display("FAIL min_done got done=%b rel=%0d want done=1 rel=7", bus_b.done, cyc - b_t0); end
        if (bus_b.peak_pow !== 48'd9) begin n_fail++; $display("FAIL min_peak_pow got=%0d want=9", bus_b.peak_pow); end
        if (bus_b.peak_phase !== 12'd1) begin n_fail++; $display("FAIL min_peak_phase got=%0d want=1", bus_b.peak_phase); end
        if (bus_b.found !== 1'b1) begin n_fail++; $display("FAIL min_found got=%b want=1", bus_b.found); end
        repeat (4) @(negedge rx_clk);
        b_run = 1'b0;
        n_tests++;
        if (q_b.size() != 0) begin n_fail++; $display("FAIL min_drain got %0d pending events want 0", q_b.size()); end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.threshold = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.threshold = '0;
        test_reset();
        test_sweep(48'd40, 1'b1, "thr40");
        test_sweep(48'd60, 1'b0, "thr60");
        test_abort();
        test_start_abort_idle();
        test_start_while_busy();
        test_async_reset();
        test_min_config();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/corr_acq_ctrl.md
Name: corr_acq_ctrl

Overview:
- Acquisition sequencer for the B1 correlator/accumulator datapath.
- Sweeps code-phase hypotheses 0..PHASE_NUM-1. For each hypothesis it loads the local code generator, frames one PRN period with single-cycle sop/eop strobes, and waits the fixed power-pipeline latency.
- Samples the resulting |I|²+|Q|² power and tracks the peak power and its phase. Flags detection against a programmable threshold.
- Sits between the channel control registers and the correlator accumulator / local code generator.

Parameters:
- PRN_LEN, 2046, chips per PRN period, one chip per clock.
- PHASE_NUM, 2046, number of code-phase hypotheses per sweep.
- PHASE_WIDTH, 12, width of code-phase index; 2^PHASE_WIDTH must be ≥ PHASE_NUM.
- POW_LAT, 3, cycles from eop strobe to valid power at corr_pow; legal range ≥ 1.
- POW_WIDTH, 48, width of power word.

Ports:
- rx_clk  in  1  clock.
- rx_rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  one-cycle request to terminate a sweep.
- threshold  in  POW_WIDTH  detection threshold, unsigned; sampled in EVAL.
- corr_pow  in  POW_WIDTH  power result from the correlator datapath, unsigned.
- tx_phase_load  out  1  one-cycle strobe: code generator loads tx_code_phase.
- tx_code_phase  out  PHASE_WIDTH  current hypothesis.
- tx_prn_sop  out  1  first chip of PRN period.
- tx_prn_eop  out  1  last chip of PRN period.
- busy  out  1  high from the cycle after an accepted start until DONE/IDLE.
- done  out  1  one-cycle pulse at end of a complete sweep.
- found  out  1  at least one hypothesis had corr_pow ≥ threshold.
- peak_pow  out  POW_WIDTH  maximum power seen this sweep.
- peak_phase  out  PHASE_WIDTH  hypothesis of peak_pow.

Behaviour:
- Reset values (async, immediate): state=IDLE; every output 0; internal chip_cnt and lat_cnt = 0.
- FSM states: IDLE, LOAD, ACCUM, WAIT_POW, EVAL, DONE.
- IDLE:
  - On start (and not abort): clear peak_pow, peak_phase and found; set tx_code_phase=0; go to LOAD.
  - Otherwise hold all outputs.
- LOAD (1 cycle):
  - tx_phase_load=1; chip_cnt=0.
  - Go to ACCUM.
- ACCUM (PRN_LEN cycles):
  - tx_prn_sop=1 when chip_cnt==0.
  - tx_prn_eop=1 when chip_cnt==PRN_LEN-1. Both strobes are asserted in the same cycle if PRN_LEN==1.
  - chip_cnt increments each cycle. After the eop cycle go to WAIT_POW with lat_cnt=1.
- WAIT_POW:
  - lat_cnt increments each cycle. When lat_cnt==POW_LAT-1 go to EVAL.
  - POW_LAT==1 skips WAIT_POW: go directly ACCUM→EVAL.
  - EVAL is therefore exactly POW_LAT cycles after the eop cycle.
- EVAL (1 cycle):
  - If corr_pow > peak_pow (strict), update peak_pow←corr_pow and peak_phase←tx_code_phase. On ties the earliest phase is kept.
  - If corr_pow ≥ threshold, set found=1. found is sticky for the rest of the sweep.
  - If tx_code_phase==PHASE_NUM-1, go to DONE. Otherwise tx_code_phase+1, then LOAD.
- DONE (1 cycle):
  - done=1, busy=0; then IDLE.
  - peak_pow, peak_phase and found hold until the next accepted start.
- Timing:
  - Per-hypothesis period = PRN_LEN+POW_LAT+1 cycles.
  - With start accepted in cycle 0: LOAD in cycle 1, first sop in cycle 2, done in cycle 1+PHASE_NUM·(PRN_LEN+POW_LAT+1).
- busy: registered; 1 in LOAD, ACCUM, WAIT_POW and EVAL; 0 in IDLE and DONE.
- abort:
  - In any non-IDLE state, the next state is IDLE. No done pulse.
  - sop, eop and phase_load are forced to 0 from the next cycle.
  - peak_pow, peak_phase and found hold their partial-sweep values.
  - abort in IDLE is ignored. abort together with start: abort wins and the sweep does not start.
- start while busy is ignored.
- threshold and corr_pow are only sampled in EVAL; changes at other times have no effect.
- Async rx_rst mid-sweep: all outputs clear to 0 immediately, including any strobe in flight.

Test Plan:
- Params PRN_LEN=8, PHASE_NUM=4, POW_LAT=3. corr_pow driven per-EVAL as 10, 50, 30, 50; threshold=40; start at cycle 0 -> phase_load at cycles 1, 13, 25, 37; sop at cycles 2, 14, …; eop at cycles 9, 21, …; done at cycle 49; peak_pow=50, peak_phase=1 (tie at phase 3 not taken); found=1.
- Same setup with threshold=60 -> found=0; peak_pow=50; peak_phase=1; done at cycle 49.
- abort in cycle 20 (ACCUM, phase 1) -> IDLE from cycle 21; no eop at 21; no done; busy=0; peak_pow=10, peak_phase=0.
- start and abort together in IDLE -> no phase_load; busy stays 0. A second start pulse during busy -> no restart; done still at cycle 49.
- rx_rst asserted asynchronously mid-cycle during ACCUM -> busy, sop, eop, found, peak_pow and tx_code_phase go to 0 without waiting for a clock edge. After release, start -> normal sweep from phase 0.
- POW_LAT=1, PRN_LEN=1, PHASE_NUM=2 -> sop and eop coincide in cycles 2 and 5; EVAL in cycles 3 and 6; done in cycle 7.
